// File: rtl/io_bus_arbiter.sv
// Two-master IO bus arbiter: grant -> transfer (io_ready or TIMEOUT) -> one-cycle ack -> idle; ack two cycles after request at best.
// Define IO_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module io_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [3:0]  m0_mode,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic [3:0]  m1_mode,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m_err,
  output logic [3:0]  io_mode,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ready
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DONE} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_m0_rdata, r_m1_rdata;
  logic        r_m0_ack, r_m1_ack, r_err;
  logic        w_v0, w_v1, w_pick1, w_grant, w_done;

  // A request carrying mode 0 is indistinguishable from no request.
  assign w_v0    = m0_req && (m0_mode != 4'd0);
  assign w_v1    = m1_req && (m1_mode != 4'd0);
  assign w_grant = (r_state == GRANT0) || (r_state == GRANT1);
  assign w_done  = w_grant && (io_ready || (r_cnt == LP_LAST));

`ifdef IO_ARB_RR_EN
  logic r_last;

  // r_last holds the previously granted master; reset value 1 lets master 0 win first.
  assign w_pick1 = w_v1 && (!w_v0 || !r_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if ((r_state == IDLE) && (w_v0 || w_v1)) begin
      r_last <= w_pick1;
    end
  end
`else
  assign w_pick1 = w_v1 && !w_v0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    io_mode  = 4'd0;
    io_addr  = 32'd0;
    io_wdata = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_v0 || w_v1) begin
          w_next = w_pick1 ? GRANT1 : GRANT0;
        end
      end
      GRANT0: begin
        io_mode  = m0_mode;
        io_addr  = m0_addr;
        io_wdata = m0_wdata;
        if (w_done) begin
          w_next = DONE;
        end
      end
      GRANT1: begin
        io_mode  = m1_mode;
        io_addr  = m1_addr;
        io_wdata = m1_wdata;
        if (w_done) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Wait counter is zero on the first grant cycle and counts cycles spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (w_grant) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_err      <= 1'b0;
      r_m0_rdata <= 32'd0;
      r_m1_rdata <= 32'd0;
    end else begin
      r_m0_ack <= w_done && (r_state == GRANT0);
      r_m1_ack <= w_done && (r_state == GRANT1);
      r_err    <= w_done && !io_ready;
      if (w_done && (r_state == GRANT0)) begin
        r_m0_rdata <= io_ready ? io_rdata : 32'd0;
      end
      if (w_done && (r_state == GRANT1)) begin
        r_m1_rdata <= io_ready ? io_rdata : 32'd0;
      end
    end
  end

  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m_err    = r_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed scenarios plus randomized transactions checked against a transaction-level model.
module tb_io_bus_arbiter;
  localparam int TO = 16;
`ifdef IO_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_ack, m1_ack, m_err, io_ready;
  logic [3:0]  m0_mode, m1_mode, io_mode;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [31:0] io_addr, io_wdata, io_rdata;

  int n_vec = 0;
  int n_err = 0;

  io_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .m_err(m_err), .io_mode(io_mode), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mode"}, 32'(io_mode), 32'd0);
    chk({tag, "_ack0"}, 32'(m0_ack), 32'd0);
    chk({tag, "_ack1"}, 32'(m1_ack), 32'd0);
    chk({tag, "_err"}, 32'(m_err), 32'd0);
  endtask

  logic        r0, r1, v0, v1, win, last;
  logic [3:0]  md0, md1, exp_mode;
  logic [31:0] rd, exp_addr, exp_wdata;
  int          d, last_i, nwin;
  logic        wins [4];

  initial begin
    rst = 1'b1; io_ready = 1'b0; io_rdata = 32'd0;
    m0_req = 1'b0; m0_mode = 4'd0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_mode = 4'd0; m1_addr = 32'd0; m1_wdata = 32'd0;
    last = 1'b1;
    #2;
    chk_quiet("reset");
    chk("reset_addr", io_addr, 32'd0);
    chk("reset_wdata", io_wdata, 32'd0);
    chk("reset_rd0", m0_rdata, 32'd0);
    chk("reset_rd1", m1_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    // io_ready with nothing requested must do nothing
    io_ready = 1'b1;
    repeat (3) begin @(negedge clk); chk_quiet("idle_ready"); end
    io_ready = 1'b0;

    // basic read from master 0, ready one cycle after grant
    m0_req = 1'b1; m0_mode = 4'd1; m0_addr = 32'h8000_0000; m0_wdata = 32'h0000_00A5;
    @(negedge clk);
    chk("b_mode_k", 32'(io_mode), 32'd1);
    chk("b_addr_k", io_addr, 32'h8000_0000);
    chk("b_wdata_k", io_wdata, 32'h0000_00A5);
    chk("b_ack_k", 32'(m0_ack), 32'd0);
    @(negedge clk);
    chk("b_mode_k1", 32'(io_mode), 32'd1);
    chk("b_ack_k1", 32'(m0_ack), 32'd0);
    io_ready = 1'b1; io_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("b_ack_k2", 32'(m0_ack), 32'd1);
    chk("b_rdata", m0_rdata, 32'h1234_5678);
    chk("b_mode_done", 32'(io_mode), 32'd0);
    chk("b_err", 32'(m_err), 32'd0);
    m0_req = 1'b0; io_ready = 1'b0;
    @(negedge clk); chk_quiet("b_after");

    // randomized transactions
    for (int t = 0; t < 40; t++) begin
      r0  = 1'($urandom_range(0, 1));
      r1  = 1'($urandom_range(0, 1));
      md0 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      md1 = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      d   = int'($urandom_range(0, TO + 2));
      @(negedge clk);
      m0_req = r0; m0_mode = md0; m0_addr = $urandom; m0_wdata = $urandom;
      m1_req = r1; m1_mode = md1; m1_addr = $urandom; m1_wdata = $urandom;
      io_ready = 1'b0;
      v0 = r0 && (md0 != 4'd0);
      v1 = r1 && (md1 != 4'd0);
      if (!v0 && !v1) begin
        repeat (2) begin @(negedge clk); chk_quiet("r_nogrant"); end
        m0_req = 1'b0; m1_req = 1'b0;
      end else begin
        win = (v0 && v1) ? (RR ? !last : 1'b0) : v1;
        last = win;
        exp_mode  = win ? md1 : md0;
        exp_addr  = win ? m1_addr : m0_addr;
        exp_wdata = win ? m1_wdata : m0_wdata;
        last_i = (d < TO) ? d : TO - 1;
        rd = 32'd0;
        for (int i = 0; i <= last_i; i++) begin
          @(negedge clk);
          chk("r_mode", 32'(io_mode), 32'(exp_mode));
          chk("r_addr", io_addr, exp_addr);
          chk("r_wdata", io_wdata, exp_wdata);
          chk("r_noack", 32'(m0_ack | m1_ack), 32'd0);
          io_ready = (i == d);
          rd = $urandom; io_rdata = rd;
        end
        @(negedge clk);
        chk("r_ack0", 32'(m0_ack), 32'(!win));
        chk("r_ack1", 32'(m1_ack), 32'(win));
        chk("r_err", 32'(m_err), 32'(d >= TO));
        chk("r_rdata", win ? m1_rdata : m0_rdata, (d < TO) ? rd : 32'd0);
        chk("r_mode_done", 32'(io_mode), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0; io_ready = 1'($urandom_range(0, 1));
        @(negedge clk); chk_quiet("r_idle");
        io_ready = 1'b0;
      end
    end

    // both masters held, slave always ready: grant order shows the policy
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    m0_req = 1'b1; m0_mode = 4'd3; m1_req = 1'b1; m1_mode = 4'd4; io_ready = 1'b1;
    nwin = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) chk("c_double_ack", 32'd1, 32'd0);
      if ((m0_ack || m1_ack) && nwin < 4) begin
        wins[nwin] = m1_ack;
        nwin++;
      end
    end
    chk("c_count", 32'(nwin), 32'd4);
    for (int k = 0; k < 4; k++) chk("c_order", 32'(wins[k]), RR ? 32'(k % 2) : 32'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (4) @(negedge clk);
    io_ready = 1'b0;

    // reset during the third grant cycle aborts, then the held request is re-granted
    m0_req = 1'b1; m0_mode = 4'd5; m0_addr = 32'hCAFE_0010; m0_wdata = 32'h5555_AAAA;
    @(negedge clk); chk("x_mode_g0", 32'(io_mode), 32'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("x_rst");
    chk("x_addr", io_addr, 32'd0);
    chk("x_wdata", io_wdata, 32'd0);
    chk("x_rd0", m0_rdata, 32'd0);
    @(negedge clk); chk_quiet("x_held");
    rst = 1'b0;
    @(negedge clk);
    chk("x_regrant", 32'(io_mode), 32'd5);
    chk("x_noack", 32'(m0_ack), 32'd0);
    io_ready = 1'b1; io_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("x_ack", 32'(m0_ack), 32'd1);
    chk("x_rdata", m0_rdata, 32'hDEAD_BEEF);
    m0_req = 1'b0; io_ready = 1'b0;
    @(negedge clk);

    // mode-0 request is never granted; master 1 then goes at the next edge
    m0_req = 1'b1; m0_mode = 4'd0;
    repeat (10) begin @(negedge clk); chk_quiet("z_mode0"); end
    m1_req = 1'b1; m1_mode = 4'd2;
    @(negedge clk);
    chk("z_m1_grant", 32'(io_mode), 32'd2);

    // master 1 times out: ack with error on the 16th cycle after the bus is driven
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      chk("t_wait_mode", 32'(io_mode), 32'd2);
      chk("t_wait_ack", 32'(m1_ack), 32'd0);
    end
    @(negedge clk);
    chk("t_ack", 32'(m1_ack), 32'd1);
    chk("t_err", 32'(m_err), 32'd1);
    chk("t_rdata", m1_rdata, 32'd0);
    chk("t_ack0", 32'(m0_ack), 32'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk); chk_quiet("t_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
